// File: rtl/ibex_rf_wb_stage.sv
// Writeback stage feeding the latch-based register file through one registered write port.
// Define IBEX_RF_WB_FWD_EN to build the same-cycle forwarding view of the pending write.
module ibex_rf_wb_stage #(
  parameter int unsigned DataWidth         = 32,
  parameter bit          RV32E             = 1'b0,
  parameter bit          DummyInstructions = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 ex_valid_i,
  output logic                 ex_ready_o,
  input  logic [4:0]           ex_waddr_i,
  input  logic [DataWidth-1:0] ex_wdata_i,
  input  logic                 ex_we_i,
  input  logic                 ex_is_load_i,
  input  logic                 ex_dummy_i,
  input  logic                 lsu_resp_valid_i,
  input  logic [DataWidth-1:0] lsu_rdata_i,
  input  logic                 lsu_err_i,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  output logic                 rf_we_o,
  output logic                 rf_dummy_wb_o,
  output logic                 instr_ret_o,
  output logic                 err_o,
  output logic                 fwd_valid_o,
  output logic [4:0]           fwd_waddr_o,
  output logic [DataWidth-1:0] fwd_wdata_o
);

  typedef enum logic [0:0] {StIdle, StWaitLoad} state_e;

  state_e               state_q, state_d;
  logic [4:0]           pend_waddr_q, pend_waddr_d;
  logic                 pend_we_q, pend_we_d;
  logic                 pend_dummy_q, pend_dummy_d;
  logic [4:0]           rf_waddr_q, rf_waddr_d;
  logic [DataWidth-1:0] rf_wdata_q, rf_wdata_d;
  logic                 rf_we_q, rf_we_d;
  logic                 rf_dummy_q, rf_dummy_d;
  logic                 instr_ret_q, instr_ret_d;
  logic                 err_q, err_d;

  // RV32E only implements x0-x15.
  function automatic logic addr_ok_e(input logic [4:0] addr);
    return !(RV32E && addr[4]);
  endfunction

  // x0 writes pass only when tagged dummy, feeding the RF dummy r0.
  function automatic logic addr_ok_x0(input logic [4:0] addr, input logic dummy);
    return (addr != 5'd0) || (DummyInstructions && dummy);
  endfunction

  logic ex_write, ld_write;
  assign ex_write = ex_we_i & addr_ok_e(ex_waddr_i) & addr_ok_x0(ex_waddr_i, ex_dummy_i);
  assign ld_write = pend_we_q & ~lsu_err_i & addr_ok_e(pend_waddr_q) &
                    addr_ok_x0(pend_waddr_q, pend_dummy_q);

  assign ex_ready_o = (state_q == StIdle);

  always_comb begin
    state_d      = state_q;
    pend_waddr_d = pend_waddr_q;
    pend_we_d    = pend_we_q;
    pend_dummy_d = pend_dummy_q;
    rf_waddr_d   = rf_waddr_q;
    rf_wdata_d   = rf_wdata_q;
    rf_we_d      = 1'b0;
    rf_dummy_d   = 1'b0;
    instr_ret_d  = 1'b0;
    err_d        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ex_valid_i) begin
          if (ex_is_load_i) begin
            pend_waddr_d = ex_waddr_i;
            pend_we_d    = ex_we_i;
            pend_dummy_d = ex_dummy_i;
            state_d      = StWaitLoad;
          end else begin
            rf_we_d     = ex_write;
            rf_dummy_d  = ex_write & ex_dummy_i;
            instr_ret_d = addr_ok_e(ex_waddr_i);
            err_d       = ~addr_ok_e(ex_waddr_i);
            if (ex_write) begin
              rf_waddr_d = ex_waddr_i;
              rf_wdata_d = ex_wdata_i;
            end
          end
        end
      end
      StWaitLoad: begin
        if (lsu_resp_valid_i) begin
          rf_we_d     = ld_write;
          rf_dummy_d  = ld_write & pend_dummy_q;
          instr_ret_d = ~lsu_err_i & addr_ok_e(pend_waddr_q);
          err_d       = lsu_err_i | ~addr_ok_e(pend_waddr_q);
          state_d     = StIdle;
          if (ld_write) begin
            rf_waddr_d = pend_waddr_q;
            rf_wdata_d = lsu_rdata_i;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      pend_waddr_q <= 5'd0;
      pend_we_q    <= 1'b0;
      pend_dummy_q <= 1'b0;
      rf_waddr_q   <= 5'd0;
      rf_wdata_q   <= '0;
      rf_we_q      <= 1'b0;
      rf_dummy_q   <= 1'b0;
      instr_ret_q  <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      pend_waddr_q <= pend_waddr_d;
      pend_we_q    <= pend_we_d;
      pend_dummy_q <= pend_dummy_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_wdata_q   <= rf_wdata_d;
      rf_we_q      <= rf_we_d;
      rf_dummy_q   <= rf_dummy_d;
      instr_ret_q  <= instr_ret_d;
      err_q        <= err_d;
    end
  end

  assign rf_waddr_o    = rf_waddr_q;
  assign rf_wdata_o    = rf_wdata_q;
  assign rf_we_o       = rf_we_q;
  assign rf_dummy_wb_o = rf_dummy_q;
  assign instr_ret_o   = instr_ret_q;
  assign err_o         = err_q;

`ifdef IBEX_RF_WB_FWD_EN
  // The RF latch is not readable in the write cycle, so expose the write here; a clean load
  // response is forwarded a cycle earlier, straight from the LSU.
  always_comb begin
    fwd_valid_o = rf_we_q;
    fwd_waddr_o = rf_waddr_q;
    fwd_wdata_o = rf_wdata_q;
    if ((state_q == StWaitLoad) && lsu_resp_valid_i && !lsu_err_i) begin
      fwd_valid_o = ld_write;
      fwd_waddr_o = pend_waddr_q;
      fwd_wdata_o = lsu_rdata_i;
    end
  end
`else
  assign fwd_valid_o = 1'b0;
  assign fwd_waddr_o = 5'd0;
  assign fwd_wdata_o = '0;
`endif

endmodule

// File: tb/tb_ibex_rf_wb_stage.sv
// Scoreboard bench for ibex_rf_wb_stage, built with RV32E=1 and DummyInstructions=1.
module tb_ibex_rf_wb_stage;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        ex_valid_i, ex_ready_o, ex_we_i, ex_is_load_i, ex_dummy_i;
  logic [4:0]  ex_waddr_i;
  logic [31:0] ex_wdata_i;
  logic        lsu_resp_valid_i, lsu_err_i;
  logic [31:0] lsu_rdata_i;
  logic [4:0]  rf_waddr_o, fwd_waddr_o;
  logic [31:0] rf_wdata_o, fwd_wdata_o;
  logic        rf_we_o, rf_dummy_wb_o, instr_ret_o, err_o, fwd_valid_o;

  ibex_rf_wb_stage #(
    .DataWidth        (32),
    .RV32E            (1'b1),
    .DummyInstructions(1'b1)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .ex_valid_i      (ex_valid_i),
    .ex_ready_o      (ex_ready_o),
    .ex_waddr_i      (ex_waddr_i),
    .ex_wdata_i      (ex_wdata_i),
    .ex_we_i         (ex_we_i),
    .ex_is_load_i    (ex_is_load_i),
    .ex_dummy_i      (ex_dummy_i),
    .lsu_resp_valid_i(lsu_resp_valid_i),
    .lsu_rdata_i     (lsu_rdata_i),
    .lsu_err_i       (lsu_err_i),
    .rf_waddr_o      (rf_waddr_o),
    .rf_wdata_o      (rf_wdata_o),
    .rf_we_o         (rf_we_o),
    .rf_dummy_wb_o   (rf_dummy_wb_o),
    .instr_ret_o     (instr_ret_o),
    .err_o           (err_o),
    .fwd_valid_o     (fwd_valid_o),
    .fwd_waddr_o     (fwd_waddr_o),
    .fwd_wdata_o     (fwd_wdata_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  typedef struct packed {
    int          cyc;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        dummy;
    logic        ret;
    logic        err;
  } exp_t;

  exp_t        sb_q[$];
  logic [4:0]  last_waddr = 5'd0;
  logic [31:0] last_wdata = 32'd0;

  // Expected result of one instruction for RV32E=1, DummyInstructions=1.
  function automatic logic will_write(input logic [4:0] a, input logic we, input logic dm,
                                      input logic lerr);
    return we && !a[4] && !((a == 5'd0) && !dm) && !lerr;
  endfunction

  task automatic push_exp(input logic [4:0] a, input logic [31:0] d, input logic we,
                          input logic dm, input logic lerr, input int at_cyc);
    exp_t e;
    e.cyc = at_cyc;
    e.we  = will_write(a, we, dm, lerr);
    if (e.we) begin
      last_waddr = a;
      last_wdata = d;
    end
    e.waddr = last_waddr;
    e.wdata = last_wdata;
    e.dummy = e.we & dm;
    e.ret   = !a[4] && !lerr;
    e.err   = a[4] || lerr;
    sb_q.push_back(e);
  endtask

  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (rf_we_o || instr_ret_o || err_o || rf_dummy_wb_o) begin
        if (sb_q.size() == 0) begin
          check_val("spurious_out", {rf_we_o, instr_ret_o, err_o, rf_dummy_wb_o}, 64'd0);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check_val("out_cycle", cyc, e.cyc);
          check_val("rf_we", rf_we_o, e.we);
          check_val("rf_waddr", rf_waddr_o, e.waddr);
          check_val("rf_wdata", rf_wdata_o, e.wdata);
          check_val("rf_dummy", rf_dummy_wb_o, e.dummy);
          check_val("instr_ret", instr_ret_o, e.ret);
          check_val("err", err_o, e.err);
        end
      end
`ifdef IBEX_RF_WB_FWD_EN
      if (!lsu_resp_valid_i) begin
        check_val("fwd_valid", fwd_valid_o, rf_we_o);
        if (rf_we_o) begin
          check_val("fwd_waddr", fwd_waddr_o, rf_waddr_o);
          check_val("fwd_wdata", fwd_wdata_o, rf_wdata_o);
        end
      end
`else
      check_val("fwd_off", {fwd_valid_o, fwd_waddr_o, fwd_wdata_o}, 64'd0);
`endif
    end
  end

  task automatic alu_op(input logic [4:0] a, input logic [31:0] d, input logic we,
                        input logic dm);
    check_val("alu_ready", ex_ready_o, 1);
    ex_valid_i   = 1'b1;
    ex_is_load_i = 1'b0;
    ex_waddr_i   = a;
    ex_wdata_i   = d;
    ex_we_i      = we;
    ex_dummy_i   = dm;
    push_exp(a, d, we, dm, 1'b0, cyc + 1);
    @(posedge clk_i);
    #1;
    ex_valid_i = 1'b0;
    ex_wdata_i = ~d;
  endtask

  task automatic load_op(input logic [4:0] a, input logic we, input logic dm, input int dly,
                         input logic [31:0] d, input logic lerr);
    check_val("ld_ready", ex_ready_o, 1);
    ex_valid_i   = 1'b1;
    ex_is_load_i = 1'b1;
    ex_waddr_i   = a;
    ex_wdata_i   = ~d;
    ex_we_i      = we;
    ex_dummy_i   = dm;
    @(posedge clk_i);
    #1;
    ex_valid_i   = 1'b0;
    ex_is_load_i = 1'b0;
    for (int i = 0; i < dly; i++) begin
      check_val("load_stall", ex_ready_o, 0);
      @(posedge clk_i);
      #1;
    end
    lsu_resp_valid_i = 1'b1;
    lsu_rdata_i      = d;
    lsu_err_i        = lerr;
    push_exp(a, d, we, dm, lerr, cyc + 1);
    #1;
    check_val("resp_stall", ex_ready_o, 0);
`ifdef IBEX_RF_WB_FWD_EN
    if (will_write(a, we, dm, lerr)) begin
      check_val("fwd_ld_valid", fwd_valid_o, 1);
      check_val("fwd_ld_waddr", fwd_waddr_o, a);
      check_val("fwd_ld_wdata", fwd_wdata_o, d);
    end
`endif
    @(posedge clk_i);
    #1;
    lsu_resp_valid_i = 1'b0;
    lsu_err_i        = 1'b0;
    check_val("ld_done_ready", ex_ready_o, 1);
  endtask

  initial begin
    rst_ni           = 1'b0;
    ex_valid_i       = 1'b0;
    ex_we_i          = 1'b0;
    ex_is_load_i     = 1'b0;
    ex_dummy_i       = 1'b0;
    ex_waddr_i       = 5'd0;
    ex_wdata_i       = 32'd0;
    lsu_resp_valid_i = 1'b0;
    lsu_rdata_i      = 32'd0;
    lsu_err_i        = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check_val("rst_ready", ex_ready_o, 1);
    check_val("rst_we", rf_we_o, 0);
    check_val("rst_dummy", rf_dummy_wb_o, 0);
    check_val("rst_ret", instr_ret_o, 0);
    check_val("rst_err", err_o, 0);
    check_val("rst_waddr", rf_waddr_o, 0);
    check_val("rst_wdata", rf_wdata_o, 0);
    check_val("rst_fwd", {fwd_valid_o, fwd_wdata_o}, 0);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Reset while a load to x5 is outstanding: the late response must not write.
    ex_valid_i   = 1'b1;
    ex_is_load_i = 1'b1;
    ex_we_i      = 1'b1;
    ex_waddr_i   = 5'd5;
    @(posedge clk_i);
    #1;
    ex_valid_i   = 1'b0;
    ex_is_load_i = 1'b0;
    check_val("midld_stall", ex_ready_o, 0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b0;
    #1;
    check_val("midld_rst_ready", ex_ready_o, 1);
    check_val("midld_rst_we", rf_we_o, 0);
    #2;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    lsu_resp_valid_i = 1'b1;
    lsu_rdata_i      = 32'h1234_5678;
    @(posedge clk_i);
    #1;
    lsu_resp_valid_i = 1'b0;
    check_val("midld_ready", ex_ready_o, 1);
    check_val("midld_no_we", rf_we_o, 0);
    @(posedge clk_i);
    #1;

    alu_op(5'd3, 32'hDEAD_BEEF, 1'b1, 1'b0);
    @(posedge clk_i);
    #1;
    load_op(5'd7, 1'b1, 1'b0, 4, 32'h0000_00A5, 1'b0);
    load_op(5'd9, 1'b1, 1'b0, 2, 32'hFFFF_0000, 1'b1);
    alu_op(5'd0, 32'h1111_1111, 1'b1, 1'b0);
    alu_op(5'd0, 32'h2222_2222, 1'b1, 1'b1);
    alu_op(5'd20, 32'h3333_3333, 1'b1, 1'b0);
    alu_op(5'd4, 32'h4444_4444, 1'b0, 1'b0);
    @(posedge clk_i);
    #1;
    alu_op(5'd1, 32'h0000_0001, 1'b1, 1'b0);
    alu_op(5'd2, 32'h0000_0002, 1'b1, 1'b0);
    alu_op(5'd3, 32'h0000_0003, 1'b1, 1'b0);
    load_op(5'd20, 1'b1, 1'b0, 1, 32'h5555_5555, 1'b0);
    load_op(5'd12, 1'b1, 1'b1, 0, 32'hCAFE_F00D, 1'b0);
    alu_op(5'd13, 32'h6666_6666, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) begin
      alu_op(5'($urandom_range(31)), $urandom, 1'($urandom_range(1)), 1'($urandom_range(1)));
    end
    repeat (3) @(posedge clk_i);
    #1;
    check_val("sb_drain", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
